// File: rtl/ctrl_pkg.sv
// Shared types and constants for the dual-rail opcode controller.
// Rail pair encoding is {_t, _f}; opcodes 1..8 are the only non-no-op values.
package ctrl_pkg;

    typedef enum logic [1:0] {
        RAIL_NULL = 2'b00,
        RAIL_D0   = 2'b01,
        RAIL_D1   = 2'b10,
        RAIL_ILL  = 2'b11
    } rail_pair_e;

    typedef enum logic {
        WAIT_DATA = 1'b0,
        WAIT_NULL = 1'b1
    } ctrl_state_e;

    localparam logic [3:0] OP_NOP       = 4'd0;
    localparam logic [3:0] OP_FIRST     = 4'd1;
    localparam logic [3:0] OP_LAST      = 4'd8;
    // Opcodes up to this value carry the operation-class flag
    localparam logic [3:0] OP_CLASS_MAX = 4'd4;

endpackage

// File: rtl/dual_rail_classify.sv
// Combinational classifier: maps one dual-rail pair onto the rail_pair_e enum.
module dual_rail_classify
    import ctrl_pkg::*;
(
    input  logic       i_t,
    input  logic       i_f,
    output rail_pair_e o_pair
);

    assign o_pair = rail_pair_e'({i_t, i_f});

endmodule

// File: rtl/dual_rail_op_controller.sv
// Four-phase dual-rail opcode controller; CTRL_ILLEGAL_DET_EN enables the sticky err flag.
// state     | meaning
// WAIT_DATA | outputs NULL (or last NULL wave), waiting for a COMPLETE opcode
// WAIT_NULL | decoded DATA held, waiting for an all-EMPTY input set
module dual_rail_op_controller
    import ctrl_pkg::*;
#(
    parameter bit NOP_ACK = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic I7_t,
    input  logic I7_f,
    input  logic I6_t,
    input  logic I6_f,
    input  logic I5_t,
    input  logic I5_f,
    input  logic I4_t,
    input  logic I4_f,
    output logic C1A1_t,
    output logic C1A1_f,
    output logic C1A0_t,
    output logic C1A0_f,
    output logic C1O_t,
    output logic C1O_f,
    output logic ack,
    output logic nop,
    output logic err
);

    logic [3:0]  w_rail_t;
    logic [3:0]  w_rail_f;
    rail_pair_e  w_pair [4];
    logic        w_complete;
    logic        w_empty;
    logic [3:0]  w_op;
    logic [1:0]  w_sel;
    logic        w_class;
    logic        w_is_op;

    ctrl_state_e r_state;
    ctrl_state_e w_state_nxt;
    logic [5:0]  r_rails;
    logic [5:0]  w_rails_nxt;
    logic        r_ack;
    logic        w_ack_nxt;
    logic        r_nop;
    logic        w_nop_nxt;

    assign w_rail_t = {I7_t, I6_t, I5_t, I4_t};
    assign w_rail_f = {I7_f, I6_f, I5_f, I4_f};

    for (genvar g = 0; g < 4; g++) begin : g_classify
        dual_rail_classify u_classify (
            .i_t    (w_rail_t[g]),
            .i_f    (w_rail_f[g]),
            .o_pair (w_pair[g])
        );
    end

    // An ILLEGAL pair is neither DATA nor NULL, so it lands in PARTIAL naturally
    always_comb begin
        w_complete = 1'b1;
        w_empty    = 1'b1;
        w_op       = '0;
        for (int k = 0; k < 4; k++) begin
            w_complete = w_complete & ((w_pair[k] == RAIL_D0) || (w_pair[k] == RAIL_D1));
            w_empty    = w_empty & (w_pair[k] == RAIL_NULL);
            w_op[k]    = (w_pair[k] == RAIL_D1);
        end
    end

    assign w_is_op = (w_op >= OP_FIRST) && (w_op <= OP_LAST);
    assign w_class = (w_op <= OP_CLASS_MAX);
    assign w_sel   = w_op[1:0] - OP_FIRST[1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_rails_nxt = r_rails;
        w_ack_nxt   = r_ack;
        w_nop_nxt   = r_nop;
        case (r_state)
            WAIT_DATA: begin
                if (w_complete) begin
                    w_state_nxt = WAIT_NULL;
                    if (w_is_op) begin
                        w_rails_nxt = {w_sel[1], ~w_sel[1], w_sel[0], ~w_sel[0], w_class, ~w_class};
                        w_ack_nxt   = 1'b1;
                        w_nop_nxt   = 1'b0;
                    end else begin
                        w_rails_nxt = '0;
                        w_ack_nxt   = NOP_ACK;
                        w_nop_nxt   = 1'b1;
                    end
                end
            end
            WAIT_NULL: begin
                if (w_empty) begin
                    w_state_nxt = WAIT_DATA;
                    w_rails_nxt = '0;
                    w_ack_nxt   = 1'b0;
                    w_nop_nxt   = 1'b0;
                end
            end
            default: w_state_nxt = WAIT_DATA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= WAIT_DATA;
            r_rails <= '0;
            r_ack   <= 1'b0;
            r_nop   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rails <= w_rails_nxt;
            r_ack   <= w_ack_nxt;
            r_nop   <= w_nop_nxt;
        end
    end

    assign {C1A1_t, C1A1_f, C1A0_t, C1A0_f, C1O_t, C1O_f} = r_rails;
    assign ack = r_ack;
    assign nop = r_nop;

`ifdef CTRL_ILLEGAL_DET_EN
    logic w_illegal;
    logic r_err;

    always_comb begin
        w_illegal = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w_illegal = w_illegal | (w_pair[k] == RAIL_ILL);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err | w_illegal;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dual_rail_op_controller.sv
// Directed testbench for dual_rail_op_controller; covers CTRL_ILLEGAL_DET_EN when defined.
module tb_dual_rail_op_controller;

    localparam bit NOP_ACK = 1'b1;
`ifdef CTRL_ILLEGAL_DET_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic I7_t = 1'b0, I7_f = 1'b0, I6_t = 1'b0, I6_f = 1'b0;
    logic I5_t = 1'b0, I5_f = 1'b0, I4_t = 1'b0, I4_f = 1'b0;
    logic C1A1_t, C1A1_f, C1A0_t, C1A0_f, C1O_t, C1O_f;
    logic ack, nop, err;

    int vectors = 0;
    int miscompares = 0;

    // {C1A1_t,C1A1_f,C1A0_t,C1A0_f,C1O_t,C1O_f}, hand-decoded for op 0..8
    logic [5:0] exp_rails [9] = '{6'b000000,
                                  6'b010110, 6'b011010, 6'b100110, 6'b101010,
                                  6'b010101, 6'b011001, 6'b100101, 6'b101001};

    wire [8:0] obs = {C1A1_t, C1A1_f, C1A0_t, C1A0_f, C1O_t, C1O_f, ack, nop, err};

    dual_rail_op_controller #(.NOP_ACK(NOP_ACK)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .I7_t   (I7_t),
        .I7_f   (I7_f),
        .I6_t   (I6_t),
        .I6_f   (I6_f),
        .I5_t   (I5_t),
        .I5_f   (I5_f),
        .I4_t   (I4_t),
        .I4_f   (I4_f),
        .C1A1_t (C1A1_t),
        .C1A1_f (C1A1_f),
        .C1A0_t (C1A0_t),
        .C1A0_f (C1A0_f),
        .C1O_t  (C1O_t),
        .C1O_f  (C1O_f),
        .ack    (ack),
        .nop    (nop),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [7:0] rails);
        {I7_t, I7_f, I6_t, I6_f, I5_t, I5_f, I4_t, I4_f} = rails;
    endtask

    function automatic logic [7:0] op_rails(input logic [3:0] op);
        logic [7:0] r;
        for (int b = 0; b < 4; b++) begin
            r[2*b +: 2] = op[b] ? 2'b10 : 2'b01;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(8'h00);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (obs !== 9'b0) begin
            miscompares++;
            $display("FAIL reset: got %b want %b", obs, 9'b0);
        end
        rst_n = 1'b1;
        step();
        vectors++;
        if (obs !== 9'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got %b want %b", obs, 9'b0);
        end
    endtask

    task automatic test_op3();
        drive(8'b01_01_10_10);
        step();
        vectors++;
        if (obs !== {6'b100110, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL op3_data: got %b want %b", obs, {6'b100110, 3'b100});
        end
        drive(8'h00);
        step();
        vectors++;
        if (obs !== 9'b0) begin
            miscompares++;
            $display("FAIL op3_null: got %b want %b", obs, 9'b0);
        end
    endtask

    task automatic test_sweep();
        for (int op = 1; op <= 8; op++) begin
            drive(op_rails(4'(op)));
            step();
            vectors++;
            if (obs !== {exp_rails[op], 3'b100}) begin
                miscompares++;
                $display("FAIL sweep_op%0d: got %b want %b", op, obs, {exp_rails[op], 3'b100});
            end
            drive(8'h00);
            step();
            vectors++;
            if (obs !== 9'b0) begin
                miscompares++;
                $display("FAIL sweep_null%0d: got %b want %b", op, obs, 9'b0);
            end
        end
    endtask

    task automatic test_nop();
        logic [3:0] nops [3] = '{4'd0, 4'd12, 4'd9};
        for (int i = 0; i < 3; i++) begin
            drive(op_rails(nops[i]));
            step();
            vectors++;
            if (obs !== {6'b000000, NOP_ACK, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL nop_op%0d: got %b want %b", nops[i], obs, {6'b0, NOP_ACK, 2'b10});
            end
            drive(8'h00);
            step();
            vectors++;
            if (obs !== 9'b0) begin
                miscompares++;
                $display("FAIL nop_null%0d: got %b want %b", nops[i], obs, 9'b0);
            end
        end
    endtask

    task automatic test_partial();
        drive(8'b10_00_00_00);
        for (int c = 0; c < 5; c++) begin
            step();
            vectors++;
            if (obs !== 9'b0) begin
                miscompares++;
                $display("FAIL partial_c%0d: got %b want %b", c, obs, 9'b0);
            end
        end
        // Completing the set from partial must then be accepted normally
        drive(op_rails(4'd8));
        step();
        vectors++;
        if (obs !== {exp_rails[8], 3'b100}) begin
            miscompares++;
            $display("FAIL partial_complete: got %b want %b", obs, {exp_rails[8], 3'b100});
        end
        drive(8'h00);
        step();
    endtask

    task automatic test_no_null_change();
        drive(op_rails(4'd2));
        step();
        drive(op_rails(4'd6));
        for (int c = 0; c < 3; c++) begin
            step();
            vectors++;
            if (obs !== {exp_rails[2], 3'b100}) begin
                miscompares++;
                $display("FAIL hold_op2_c%0d: got %b want %b", c, obs, {exp_rails[2], 3'b100});
            end
        end
        // Partial-NULL (one pair still DATA) is not EMPTY either
        drive(8'b00_00_00_01);
        step();
        vectors++;
        if (obs !== {exp_rails[2], 3'b100}) begin
            miscompares++;
            $display("FAIL hold_partial_null: got %b want %b", obs, {exp_rails[2], 3'b100});
        end
        drive(8'h00);
        step();
        vectors++;
        if (obs !== 9'b0) begin
            miscompares++;
            $display("FAIL hold_release: got %b want %b", obs, 9'b0);
        end
    endtask

    task automatic test_reset_midwave();
        drive(op_rails(4'd5));
        step();
        vectors++;
        if (obs !== {exp_rails[5], 3'b100}) begin
            miscompares++;
            $display("FAIL midwave_data: got %b want %b", obs, {exp_rails[5], 3'b100});
        end
        rst_n = 1'b0;
        step();
        vectors++;
        if (obs !== 9'b0) begin
            miscompares++;
            $display("FAIL midwave_reset: got %b want %b", obs, 9'b0);
        end
        drive(8'h00);
        rst_n = 1'b1;
        step();
        // Back in WAIT_DATA: a fresh opcode is accepted immediately
        drive(op_rails(4'd7));
        step();
        vectors++;
        if (obs !== {exp_rails[7], 3'b100}) begin
            miscompares++;
            $display("FAIL midwave_resume: got %b want %b", obs, {exp_rails[7], 3'b100});
        end
        drive(8'h00);
        step();
    endtask

    task automatic test_illegal();
        drive(8'b01_01_11_10);
        step();
        vectors++;
        if (obs !== {6'b000000, 1'b0, 1'b0, ILL_EN}) begin
            miscompares++;
            $display("FAIL illegal_set: got %b want %b", obs, {6'b0, 2'b00, ILL_EN});
        end
        drive(8'h00);
        repeat (2) step();
        vectors++;
        if (obs !== {6'b000000, 1'b0, 1'b0, ILL_EN}) begin
            miscompares++;
            $display("FAIL illegal_sticky: got %b want %b", obs, {6'b0, 2'b00, ILL_EN});
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        vectors++;
        if (obs !== 9'b0) begin
            miscompares++;
            $display("FAIL illegal_clear: got %b want %b", obs, 9'b0);
        end
    endtask

    initial begin
        test_reset();
        test_op3();
        test_sweep();
        test_nop();
        test_partial();
        test_no_null_change();
        test_reset_midwave();
        test_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
